// File: rtl/data_mem_lsu.sv
// ---------------------------------------------------------------------------
// data_mem_lsu
//
// Byte-addressed data memory with a load/store unit for a single-cycle RV32I
// core. Stores commit on the rising clock edge with byte-lane enables. Loads
// are combinational and return width-formatted, sign- or zero-extended data.
// Misaligned or illegal accesses are suppressed and recorded in sticky status
// registers.
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words (power of 2, >= 4)
//   AW            derived word-index width
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-high reset (clears memory and status)
//   mem_write_en  store request this cycle
//   mem_read_en   load request this cycle (gates fault tracking only)
//   s_type        store funct3: 000 SB, 001 SH, 010 SW
//   l_type        load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   mem_addr      byte address (core ALU result)
//   mem_wdata     store data, source bytes taken from the LSBs
//   mem_rdata     formatted load data
//   misalign_err  sticky flag: a misaligned or illegal access occurred
//   fault_addr    address of the first faulting access since reset
//   store_cnt     number of committed stores, wraps at 2^32
// ---------------------------------------------------------------------------
module data_mem_lsu #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  input  logic [2:0]  s_type,
  input  logic [2:0]  l_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        misalign_err,
  output logic [31:0] fault_addr,
  output logic [31:0] store_cnt
);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;

  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic          store_ok;
  logic          store_fault;

  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          load_ok;
  logic          load_fault;
  logic          any_fault;

  // Upper address bits are deliberately ignored so addresses alias modulo
  // the memory size; folding them here keeps them visibly consumed.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:AW+2];

  assign word_idx = mem_addr[AW+1:2];
  assign lane     = mem_addr[1:0];

  // Store decode: lane enables, legality and data replicated across lanes so
  // every enabled lane simply picks its own byte position.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = mem_wdata;
    store_ok  = 1'b0;
    case (s_type)
      3'b000: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{mem_wdata[7:0]}};
        store_ok  = 1'b1;
      end
      3'b001: begin
        byte_en   = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{mem_wdata[15:0]}};
        store_ok  = ~mem_addr[0];
      end
      3'b010: begin
        byte_en   = 4'b1111;
        wdata_rep = mem_wdata;
        store_ok  = (lane == 2'b00);
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = mem_wdata;
        store_ok  = 1'b0;
      end
    endcase
  end

  assign store_fault = mem_write_en & ~store_ok;

  // Load path is purely combinational; a faulting load format returns zero
  // whether or not mem_read_en is asserted.
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = mem_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    mem_rdata = 32'h0;
    load_ok   = 1'b0;
    case (l_type)
      3'b000: begin
        mem_rdata = {{24{rd_byte[7]}}, rd_byte};
        load_ok   = 1'b1;
      end
      3'b001: begin
        mem_rdata = {{16{rd_half[15]}}, rd_half};
        load_ok   = ~mem_addr[0];
      end
      3'b010: begin
        mem_rdata = rd_word;
        load_ok   = (lane == 2'b00);
      end
      3'b100: begin
        mem_rdata = {24'h0, rd_byte};
        load_ok   = 1'b1;
      end
      3'b101: begin
        mem_rdata = {16'h0, rd_half};
        load_ok   = ~mem_addr[0];
      end
      default: begin
        mem_rdata = 32'h0;
        load_ok   = 1'b0;
      end
    endcase
    if (!load_ok) mem_rdata = 32'h0;
  end

  assign load_fault = mem_read_en & ~load_ok;
  assign any_fault  = store_fault | load_fault;

  // Memory array: reset wipes every word so nothing ever reads as X; a legal
  // store updates only its enabled lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_write_en && store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Status: the error flag is sticky and only the first fault since reset
  // captures its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
      fault_addr   <= 32'h0;
      store_cnt    <= 32'h0;
    end else begin
      if (any_fault) begin
        misalign_err <= 1'b1;
        if (!misalign_err) fault_addr <= mem_addr;
      end
      if (mem_write_en && store_ok) store_cnt <= store_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_data_mem_lsu
//
// Directed self-checking bench for data_mem_lsu: reset behaviour, byte/half
// stores with sign/zero-extended loads, misaligned and illegal accesses,
// address aliasing, reset priority over a store and read-during-write.
// ---------------------------------------------------------------------------
module tb_data_mem_lsu;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk;
  logic        reset;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [2:0]  s_type;
  logic [2:0]  l_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        misalign_err;
  logic [31:0] fault_addr;
  logic [31:0] store_cnt;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.DEPTH_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .s_type       (s_type),
    .l_type       (l_type),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .misalign_err (misalign_err),
    .fault_addr   (fault_addr),
    .store_cnt    (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs and let the combinational read path settle.
  task automatic applyStimulus(input logic we, input logic re,
                               input logic [2:0] st, input logic [2:0] lt,
                               input logic [31:0] addr, input logic [31:0] wdata);
    mem_write_en = we;
    mem_read_en  = re;
    s_type       = st;
    l_type       = lt;
    mem_addr     = addr;
    mem_wdata    = wdata;
    #1;
  endtask

  // Advance one rising edge and step clear of it before anything is sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit one store on the next edge, then drop the request.
  task automatic doStore(input logic [2:0] st, input logic [31:0] addr,
                         input logic [31:0] wdata);
    applyStimulus(1'b1, 1'b0, st, LW, addr, wdata);
    tick();
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h0, 32'h0);
  endtask

  // Combinational load lookup without requesting fault tracking.
  task automatic peek(input logic [2:0] lt, input logic [31:0] addr);
    applyStimulus(1'b0, 1'b0, SW, lt, addr, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // T1: reset clears a previously written word and all status.
    doStore(SW, 32'h10, 32'hDEADBEEF);
    peek(LW, 32'h10);
    checkOutput("t1_pre_reset_lw", mem_rdata, 32'hDEADBEEF);
    checkOutput("t1_pre_reset_cnt", store_cnt, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek(LW, 32'h10);
    checkOutput("t1_lw_after_reset", mem_rdata, 32'h0);
    checkOutput("t1_err_after_reset", {31'h0, misalign_err}, 32'h0);
    checkOutput("t1_cnt_after_reset", store_cnt, 32'h0);
    checkOutput("t1_faddr_after_reset", fault_addr, 32'h0);

    // T2: byte/half stores merged into one word, signed and unsigned loads.
    doStore(SW, 32'h20, 32'h11223344);
    doStore(SB, 32'h21, 32'h00000080);
    doStore(SH, 32'h22, 32'h0000F00D);
    peek(LW, 32'h20);
    checkOutput("t2_lw_merged", mem_rdata, 32'hF00D8044);
    peek(LB, 32'h21);
    checkOutput("t2_lb_sign", mem_rdata, 32'hFFFFFF80);
    peek(LBU, 32'h21);
    checkOutput("t2_lbu_zero", mem_rdata, 32'h00000080);
    peek(LH, 32'h22);
    checkOutput("t2_lh_sign", mem_rdata, 32'hFFFFF00D);
    peek(LHU, 32'h22);
    checkOutput("t2_lhu_zero", mem_rdata, 32'h0000F00D);
    peek(LBU, 32'h20);
    checkOutput("t2_lbu_lane0_kept", mem_rdata, 32'h00000044);
    checkOutput("t2_cnt", store_cnt, 32'd3);
    checkOutput("t2_no_err", {31'h0, misalign_err}, 32'h0);

    // Read-during-write: old contents before the edge, new contents after.
    applyStimulus(1'b1, 1'b1, SW, LW, 32'h24, 32'h00000055);
    checkOutput("rdw_old", mem_rdata, 32'h0);
    tick();
    checkOutput("rdw_new", mem_rdata, 32'h00000055);
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h0, 32'h0);
    checkOutput("rdw_cnt", store_cnt, 32'd4);

    // T3: misaligned word store is dropped and recorded.
    doStore(SW, 32'h31, 32'hCAFEBABE);
    peek(LW, 32'h30);
    checkOutput("t3_lw_untouched", mem_rdata, 32'h0);
    checkOutput("t3_err", {31'h0, misalign_err}, 32'h1);
    checkOutput("t3_faddr", fault_addr, 32'h31);
    checkOutput("t3_cnt_unchanged", store_cnt, 32'd4);
    applyStimulus(1'b0, 1'b1, SW, LH, 32'h33, 32'h0);
    checkOutput("t3_lh_misaligned_zero", mem_rdata, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h0, 32'h0);
    checkOutput("t3_faddr_first_wins", fault_addr, 32'h31);
    checkOutput("t3_err_sticky", {31'h0, misalign_err}, 32'h1);

    // T4: addresses wrap modulo 1 KiB.
    doStore(SW, 32'h400, 32'h12345678);
    peek(LW, 32'h000);
    checkOutput("t4_alias", mem_rdata, 32'h12345678);
    peek(LW, 32'h3FC);
    checkOutput("t4_top_untouched", mem_rdata, 32'h0);
    checkOutput("t4_cnt", store_cnt, 32'd5);

    // T5: reset wins over a same-cycle store.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, SW, LW, 32'h40, 32'hAAAA5555);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h40, 32'h0);
    checkOutput("t5_no_write", mem_rdata, 32'h0);
    checkOutput("t5_cnt", store_cnt, 32'h0);
    checkOutput("t5_err_cleared", {31'h0, misalign_err}, 32'h0);
    peek(LW, 32'h000);
    checkOutput("t5_alias_cleared", mem_rdata, 32'h0);

    // Misaligned load with read_en low reads zero and does not flag a fault.
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h41, 32'h0);
    checkOutput("nore_lw_zero", mem_rdata, 32'h0);
    tick();
    checkOutput("nore_no_err", {31'h0, misalign_err}, 32'h0);

    // T6: illegal store type is dropped and flagged.
    doStore(3'b011, 32'h50, 32'h77777777);
    peek(LW, 32'h50);
    checkOutput("t6_no_write", mem_rdata, 32'h0);
    checkOutput("t6_err", {31'h0, misalign_err}, 32'h1);
    checkOutput("t6_faddr", fault_addr, 32'h50);
    checkOutput("t6_cnt", store_cnt, 32'h0);

    // A later illegal load type leaves the first fault address in place.
    applyStimulus(1'b0, 1'b1, SW, 3'b011, 32'h60, 32'h0);
    checkOutput("illegal_lt_zero", mem_rdata, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, SW, LW, 32'h0, 32'h0);
    checkOutput("illegal_lt_faddr_kept", fault_addr, 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
